time_loader: RTL and testbench

//  Inverse of the count-to-digits parser. Accepts a wall-clock time as six BCD digits (HH:MM:SS).

---
 rtl/time_loader.sv | 135 +++++++++++++
 tb/tb_time_loader.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/time_loader.sv
// time_loader: validates a BCD HH:MM:SS digit set, converts it to ticks with a shift-add multiplier,
// and owns the 24h-wrapping tick counter. Build macro TIME_LOADER_SAT_EN saturates bad fields instead of rejecting.
module time_loader #(
   parameter int IN_BITS      = 30,
   parameter int TICK_PER_SEC = 9537,
   parameter int MUL_BITS     = $clog2(TICK_PER_SEC + 1)
) (
   input  logic               clk,
   input  logic               reset_n,
   input  logic               run_en,
   input  logic               load_valid,
   output logic               load_ready,
   input  logic [3:0]         hours_tens,
   input  logic [3:0]         hours_ones,
   input  logic [3:0]         minutes_tens,
   input  logic [3:0]         minutes_ones,
   input  logic [3:0]         seconds_tens,
   input  logic [3:0]         seconds_ones,
   output logic [IN_BITS-1:0] count,
   output logic               load_done,
   output logic               load_err
);
   localparam logic [IN_BITS-1:0]  COUNT_MAX  = IN_BITS'(64'(86400) * 64'(TICK_PER_SEC) - 64'd1);
   localparam logic [MUL_BITS-1:0] TICK_CONST = MUL_BITS'(TICK_PER_SEC);
   localparam int                  IDX_W      = (MUL_BITS > 1) ? $clog2(MUL_BITS) : 1;
   localparam logic [IDX_W-1:0]    LAST_IDX   = IDX_W'(MUL_BITS - 1);

   typedef enum logic [1:0] {IDLE, CHECK, MUL, LOAD} state_t;

   state_t              state_reg;
   logic [IN_BITS-1:0]  count_reg;
   logic [IN_BITS-1:0]  product_reg;
   logic [IN_BITS-1:0]  mcand_reg;
   logic [MUL_BITS-1:0] mult_reg;
   logic [IDX_W-1:0]    idx_reg;
   logic                load_done_reg;
   logic                load_err_reg;
   // Digit order: 0 sec ones, 1 sec tens, 2 min ones, 3 min tens, 4 hrs ones, 5 hrs tens
   logic [3:0]          digit_reg [6];

   logic [5:0]  digit_ok;
   logic [7:0]  hrs_wide, min_wide, sec_wide;
   logic        hrs_ok, min_ok, sec_ok, set_ok;
   logic [4:0]  hrs_val;
   logic [5:0]  min_val, sec_val;
   logic [16:0] sec_total;

   generate
      for (genvar gi = 0; gi < 6; gi++) begin : g_digit
         assign digit_ok[gi] = (digit_reg[gi] <= 4'd9);
      end
   endgenerate

   // Invalid fields fall back to their maximum; only matters when saturation is built in.
   always_comb begin
      hrs_wide  = {4'b0, digit_reg[5]} * 8'd10 + {4'b0, digit_reg[4]};
      min_wide  = {4'b0, digit_reg[3]} * 8'd10 + {4'b0, digit_reg[2]};
      sec_wide  = {4'b0, digit_reg[1]} * 8'd10 + {4'b0, digit_reg[0]};
      hrs_ok    = digit_ok[5] && digit_ok[4] && (hrs_wide <= 8'd23);
      min_ok    = digit_ok[3] && digit_ok[2] && (digit_reg[3] <= 4'd5);
      sec_ok    = digit_ok[1] && digit_ok[0] && (digit_reg[1] <= 4'd5);
      set_ok    = hrs_ok && min_ok && sec_ok;
      hrs_val   = hrs_ok ? hrs_wide[4:0] : 5'd23;
      min_val   = min_ok ? min_wide[5:0] : 6'd59;
      sec_val   = sec_ok ? sec_wide[5:0] : 6'd59;
      sec_total = {12'b0, hrs_val} * 17'd3600 + {11'b0, min_val} * 17'd60 + {11'b0, sec_val};
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_reg     <= IDLE;
         count_reg     <= '0;
         product_reg   <= '0;
         mcand_reg     <= '0;
         mult_reg      <= '0;
         idx_reg       <= '0;
         load_done_reg <= 1'b0;
         load_err_reg  <= 1'b0;
         for (int i = 0; i < 6; i++) digit_reg[i] <= '0;
      end else begin
         load_done_reg <= 1'b0;
         load_err_reg  <= 1'b0;

         // A completing conversion overrides both increment and wrap.
         if (state_reg == LOAD)
            count_reg <= product_reg;
         else if (run_en)
            count_reg <= (count_reg == COUNT_MAX) ? '0 : count_reg + IN_BITS'(1);

         case (state_reg)
            IDLE: begin
               if (load_valid) begin
                  digit_reg[0] <= seconds_ones;
                  digit_reg[1] <= seconds_tens;
                  digit_reg[2] <= minutes_ones;
                  digit_reg[3] <= minutes_tens;
                  digit_reg[4] <= hours_ones;
                  digit_reg[5] <= hours_tens;
                  state_reg    <= CHECK;
               end
            end
            CHECK: begin
               mcand_reg    <= IN_BITS'(sec_total);
               mult_reg     <= TICK_CONST;
               product_reg  <= '0;
               idx_reg      <= '0;
               load_err_reg <= !set_ok;
`ifdef TIME_LOADER_SAT_EN
               state_reg    <= MUL;
`else
               state_reg    <= set_ok ? MUL : IDLE;
`endif
            end
            MUL: begin
               if (mult_reg[0]) product_reg <= product_reg + mcand_reg;
               mcand_reg <= mcand_reg << 1;
               mult_reg  <= mult_reg >> 1;
               idx_reg   <= idx_reg + IDX_W'(1);
               if (idx_reg == LAST_IDX) state_reg <= LOAD;
            end
            LOAD: begin
               load_done_reg <= 1'b1;
               state_reg     <= IDLE;
            end
            default: state_reg <= IDLE;
         endcase
      end
   end

   assign load_ready = (state_reg == IDLE);
   assign count      = count_reg;
   assign load_done  = load_done_reg;
   assign load_err   = load_err_reg;

endmodule

// File: tb/tb_time_loader.sv
// Bench for time_loader: an event-scheduled model checked every cycle, plus directed loads with literal results.
module tb_time_loader;
   localparam int     IN_BITS = 30;
   localparam int     TPS     = 9537;
   localparam longint CMAX    = 64'd86400 * TPS - 1;

   logic               clk = 1'b0;
   logic               reset_n = 1'b0;
   logic               run_en = 1'b0;
   logic               load_valid = 1'b0;
   logic               load_ready;
   logic [3:0]         ht = '0, ho = '0, mt = '0, mo = '0, st = '0, so = '0;
   logic [IN_BITS-1:0] count;
   logic               load_done;
   logic               load_err;

   int n_total = 0;
   int n_pass  = 0;

   time_loader #(.IN_BITS(IN_BITS), .TICK_PER_SEC(TPS)) dut (
      .clk(clk), .reset_n(reset_n), .run_en(run_en),
      .load_valid(load_valid), .load_ready(load_ready),
      .hours_tens(ht), .hours_ones(ho), .minutes_tens(mt), .minutes_ones(mo),
      .seconds_tens(st), .seconds_ones(so),
      .count(count), .load_done(load_done), .load_err(load_err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input longint act, input longint exp);
      n_total++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
   endtask

   // Field rules in plain arithmetic; out-of-range fields take their maximum (used only when saturating).
   function automatic void decode(input logic [23:0] d, output bit ok, output longint secs);
      int h1, h0, m1, m0, s1, s0, h, m, s;
      bit h_ok, m_ok, s_ok;
      h1 = int'(d[23:20]); h0 = int'(d[19:16]);
      m1 = int'(d[15:12]); m0 = int'(d[11:8]);
      s1 = int'(d[7:4]);   s0 = int'(d[3:0]);
      h_ok = (h1 <= 9) && (h0 <= 9) && (h1 * 10 + h0 <= 23);
      m_ok = (m1 <= 5) && (m0 <= 9);
      s_ok = (s1 <= 5) && (s0 <= 9);
      h = h_ok ? h1 * 10 + h0 : 23;
      m = m_ok ? m1 * 10 + m0 : 59;
      s = s_ok ? s1 * 10 + s0 : 59;
      ok = h_ok && m_ok && s_ok;
      secs = longint'(h) * 3600 + longint'(m) * 60 + longint'(s);
   endfunction

   // Model: each accepted set schedules an error pulse one edge later and a load sixteen edges later.
   int     cyc = 0;
   int     acc_edge = 0;
   int     m_load_edge = 0;
   int     m_err_edge = 0;
   bit     m_busy = 1'b0;
   bit     m_bad = 1'b0;
   bit     m_done = 1'b0;
   bit     m_err = 1'b0;
   longint m_count = 0;
   longint m_value = 0;

   always @(posedge clk) begin
      bit     rdy;
      bit     ok;
      longint secs;
      cyc++;
      rdy = !m_busy;
      m_done = 1'b0;
      m_err  = 1'b0;
      if (!reset_n) begin
         m_count = 0;
         m_busy  = 1'b0;
      end else begin
         if (m_busy && cyc == m_load_edge) begin
            m_count = m_value;
            m_done  = 1'b1;
            m_busy  = 1'b0;
         end else if (run_en) begin
            m_count = (m_count == CMAX) ? 0 : m_count + 1;
         end
         if (m_busy && cyc == m_err_edge && m_bad) begin
            m_err = 1'b1;
`ifndef TIME_LOADER_SAT_EN
            m_busy = 1'b0;
`endif
         end
         if (rdy && load_valid) begin
            decode({ht, ho, mt, mo, st, so}, ok, secs);
            m_value     = secs * TPS;
            m_bad       = !ok;
            m_busy      = 1'b1;
            acc_edge    = cyc;
            m_err_edge  = cyc + 1;
            m_load_edge = cyc + 16;
         end
      end
   end

   always @(posedge clk) begin
      #1;
      chk("cyc_count", longint'(count), m_count);
      chk("cyc_load_done", longint'(load_done), longint'(m_done));
      chk("cyc_load_err", longint'(load_err), longint'(m_err));
      chk("cyc_load_ready", longint'(load_ready), longint'(!m_busy));
   end

   task automatic set_digits(input logic [23:0] d);
      {ht, ho, mt, mo, st, so} = d;
   endtask

   task automatic wait_result(input bit want_done, output bit got_done, output bit got_err,
                              output int done_lat, output int err_lat);
      bit fin = 1'b0;
      got_done = 1'b0; got_err = 1'b0; done_lat = -1; err_lat = -1;
      for (int i = 0; i < 40 && !fin; i++) begin
         if (load_err && !got_err) begin
            got_err = 1'b1;
            err_lat = cyc - acc_edge;
         end
         if (load_done) begin
            got_done = 1'b1;
            done_lat = cyc - acc_edge;
            fin = 1'b1;
         end else if (got_err && !want_done) begin
            fin = 1'b1;
         end else begin
            @(negedge clk);
         end
      end
      if (!fin) chk("result_timeout", 0, 1);
   endtask

   task automatic load_and_check(input string name, input logic [23:0] d, input bit exp_err,
                                 input bit exp_done, input longint exp_count);
      bit gd, ge;
      int dl, el;
      set_digits(d);
      load_valid = 1'b1;
      @(negedge clk);
      load_valid = 1'b0;
      chk({name, "_ready_low"}, longint'(load_ready), 0);
      wait_result(exp_done, gd, ge, dl, el);
      chk({name, "_err_seen"}, longint'(ge), longint'(exp_err));
      if (exp_err) chk({name, "_err_lat"}, el, 1);
      chk({name, "_done_seen"}, longint'(gd), longint'(exp_done));
      if (exp_done) chk({name, "_done_lat"}, dl, 16);
      chk({name, "_count"}, longint'(count), exp_count);
      $display("load %s %h: err=%0d done=%0d count=%0d", name, d, ge, gd, count);
   endtask

   initial begin
      bit gd, ge, seen;
      int dl, el;

      repeat (3) @(negedge clk);
      chk("rst_count", longint'(count), 0);
      chk("rst_ready", longint'(load_ready), 1);
      chk("rst_done", longint'(load_done), 0);
      chk("rst_err", longint'(load_err), 0);
      reset_n = 1'b1;
      @(negedge clk);

      load_and_check("t123456", 24'h123456, 1'b0, 1'b1, 431987952);

      run_en = 1'b1;
      load_and_check("t235959", 24'h235959, 1'b0, 1'b1, 823987263);
      repeat (9536) @(negedge clk);
      chk("pre_wrap", longint'(count), 823996799);
      @(negedge clk);
      chk("wrap", longint'(count), 0);
      run_en = 1'b0;
      @(negedge clk);

`ifdef TIME_LOADER_SAT_EN
      load_and_check("h24", 24'h240000, 1'b1, 1'b1, 789663600);
      load_and_check("s_a", 24'h00000A, 1'b1, 1'b1, 562683);
      load_and_check("m60", 24'h126000, 1'b1, 1'b1, 445759380);
`else
      load_and_check("h24", 24'h240000, 1'b1, 1'b0, 0);
      load_and_check("s_a", 24'h00000A, 1'b1, 1'b0, 0);
      load_and_check("m60", 24'h126000, 1'b1, 1'b0, 0);
`endif
      @(negedge clk);
      load_and_check("t190703", 24'h190703, 1'b0, 1'b1, 656364951);

      // Second set held on load_valid throughout the first conversion.
      @(negedge clk);
      set_digits(24'h010203);
      load_valid = 1'b1;
      @(negedge clk);
      set_digits(24'h020000);
      chk("b2b_ready_low", longint'(load_ready), 0);
      wait_result(1'b1, gd, ge, dl, el);
      chk("b2b_first_lat", dl, 16);
      chk("b2b_first_count", longint'(count), 35506251);
      $display("load b2b_first 010203: done=%0d count=%0d", gd, count);
      @(negedge clk);
      load_valid = 1'b0;
      chk("b2b_second_busy", longint'(load_ready), 0);
      wait_result(1'b1, gd, ge, dl, el);
      chk("b2b_second_lat", dl, 16);
      chk("b2b_second_count", longint'(count), 68666400);
      $display("load b2b_second 020000: done=%0d count=%0d", gd, count);

      // Reset asserted at the fifth edge of a conversion.
      @(negedge clk);
      run_en = 1'b1;
      set_digits(24'h001000);
      load_valid = 1'b1;
      @(negedge clk);
      load_valid = 1'b0;
      repeat (4) @(negedge clk);
      reset_n = 1'b0;
      @(negedge clk);
      chk("midrst_count", longint'(count), 0);
      chk("midrst_ready", longint'(load_ready), 1);
      chk("midrst_done", longint'(load_done), 0);
      reset_n = 1'b1;
      run_en  = 1'b0;
      seen = 1'b0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (load_done) seen = 1'b1;
      end
      chk("midrst_no_done", longint'(seen), 0);
      $display("load midrst 001000: discarded, count=%0d", count);
      load_and_check("fresh", 24'h000001, 1'b0, 1'b1, 9537);

      repeat (3) @(negedge clk);
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule
